// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin arbiter onto the iosystem even/odd byte-bank register port
module io_bus_arbiter #(
  parameter int          NUM_REQ    = 2,
  parameter logic [14:0] IDLE_RADDR = 15'h7FFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ-1:0]     req_wide,
  input  logic [16*NUM_REQ-1:0]  req_addr,
  input  logic [16*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_rdata,
  output logic                   busy,
  output logic [14:0]            read_addr_even,
  output logic [14:0]            read_addr_odd,
  output logic [14:0]            write_addr_even,
  output logic [14:0]            write_addr_odd,
  output logic [7:0]             write_data_even,
  output logic [7:0]             write_data_odd,
  output logic                   write_en_even,
  output logic                   write_en_odd,
  input  logic [7:0]             read_data_even,
  input  logic [7:0]             read_data_odd
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [14:0] IDLE_WADDR = IDLE_RADDR ^ 15'h0001;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        prio;
  logic                 grant_found;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        scan_idx;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 accept;

  logic                 sel_write, sel_wide;
  logic [15:0]          sel_addr, sel_wdata;
  logic [14:0]          word_idx, word_idx_inc;
  logic [14:0]          even_idx, odd_idx;
  logic                 even_used, odd_used;
  logic [7:0]           even_byte, odd_byte;

  logic                 lat_write, lat_wide, lat_odd;
  logic [PW-1:0]        lat_idx;
  logic [NUM_REQ-1:0]   lat_oh;
  logic [7:0]           lo_byte, hi_byte;

  logic [14:0]          ra_even_n, ra_odd_n, wa_even_n, wa_odd_n;
  logic [7:0]           wd_even_n, wd_odd_n;
  logic                 we_even_n, we_odd_n;
  logic [NUM_REQ-1:0]   rsp_valid_n;
  logic [15:0]          rsp_rdata_n;

  // Round-robin search starting at the current highest-priority requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((int'(prio) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // One-hot forms of the live grant and of the in-flight requester
  always_comb begin
    grant_oh = '0;
    lat_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_found && (grant_idx == PW'(i));
      lat_oh[i]   = (lat_idx == PW'(i));
    end
  end

  assign accept    = (state == S_IDLE) && grant_found;
  assign req_ready = (state == S_IDLE) ? grant_oh : '0;
  assign busy      = (state != S_IDLE);

  // Byte-lane mapping of the winning request: low byte lands on the bank picked by A[0]
  always_comb begin
    sel_write    = req_write[grant_idx];
    sel_wide     = req_wide[grant_idx];
    sel_addr     = req_addr[16*grant_idx +: 16];
    sel_wdata    = req_wdata[16*grant_idx +: 16];
    word_idx     = sel_addr[15:1];
    word_idx_inc = word_idx + 15'd1;
    odd_idx      = word_idx;
    even_idx     = sel_addr[0] ? word_idx_inc : word_idx;
    even_used    = !sel_addr[0] || sel_wide;
    odd_used     = sel_addr[0] || sel_wide;
    even_byte    = sel_addr[0] ? sel_wdata[15:8] : sel_wdata[7:0];
    odd_byte     = sel_addr[0] ? sel_wdata[7:0]  : sel_wdata[15:8];
  end

  // State register plus the request latch and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      prio      <= '0;
      lat_write <= 1'b0;
      lat_wide  <= 1'b0;
      lat_odd   <= 1'b0;
      lat_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_write <= sel_write;
        lat_wide  <= sel_wide;
        lat_odd   <= sel_addr[0];
        lat_idx   <= grant_idx;
        prio      <= (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Next state: writes finish after ISSUE, reads spend one extra cycle for the bank latency
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_write ? S_IDLE : S_WAIT;
      S_WAIT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; read and write index of a lane always differ in bit 0
  always_comb begin
    ra_even_n   = IDLE_RADDR;
    ra_odd_n    = IDLE_RADDR;
    wa_even_n   = IDLE_WADDR;
    wa_odd_n    = IDLE_WADDR;
    wd_even_n   = 8'h00;
    wd_odd_n    = 8'h00;
    we_even_n   = 1'b0;
    we_odd_n    = 1'b0;
    lo_byte     = lat_odd ? read_data_odd  : read_data_even;
    hi_byte     = lat_odd ? read_data_even : read_data_odd;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata;
    if (accept) begin
      if (even_used) begin
        if (sel_write) begin
          wa_even_n = even_idx;
          wd_even_n = even_byte;
          we_even_n = 1'b1;
          ra_even_n = even_idx ^ 15'h0001;
        end else begin
          ra_even_n = even_idx;
          wa_even_n = even_idx ^ 15'h0001;
        end
      end
      if (odd_used) begin
        if (sel_write) begin
          wa_odd_n = odd_idx;
          wd_odd_n = odd_byte;
          we_odd_n = 1'b1;
          ra_odd_n = odd_idx ^ 15'h0001;
        end else begin
          ra_odd_n = odd_idx;
          wa_odd_n = odd_idx ^ 15'h0001;
        end
      end
    end
    if (state == S_ISSUE && lat_write) begin
      rsp_valid_n = lat_oh;
    end
    if (state == S_WAIT) begin
      rsp_valid_n = lat_oh;
      rsp_rdata_n = lat_wide ? {hi_byte, lo_byte} : {8'h00, lo_byte};
    end
  end

  // Output registers: bank port, completion pulse and held read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr_even  <= IDLE_RADDR;
      read_addr_odd   <= IDLE_RADDR;
      write_addr_even <= IDLE_WADDR;
      write_addr_odd  <= IDLE_WADDR;
      write_data_even <= 8'h00;
      write_data_odd  <= 8'h00;
      write_en_even   <= 1'b0;
      write_en_odd    <= 1'b0;
      rsp_valid       <= '0;
      rsp_rdata       <= 16'h0000;
    end else begin
      read_addr_even  <= ra_even_n;
      read_addr_odd   <= ra_odd_n;
      write_addr_even <= wa_even_n;
      write_addr_odd  <= wa_odd_n;
      write_data_even <= wd_even_n;
      write_data_odd  <= wd_odd_n;
      write_en_even   <= we_even_n;
      write_en_odd    <= we_odd_n;
      rsp_valid       <= rsp_valid_n;
      rsp_rdata       <= rsp_rdata_n;
    end
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the iosystem dual-bank (even/odd byte) peripheral register port among NUM_REQ requesters, e.g. the CPU and a DMA engine.
- Converts byte-addressed 8/16-bit requests into even/odd bank addresses, data and write enables.
- Sequences the one-cycle registered read latency of the iosystem.
- Keeps the iosystem read-equals-write forwarding path from corrupting read data.

Parameters:
NUM_REQ, 2, number of requesters (1..4); index 0 has highest priority after reset
IDLE_RADDR, 15'h7FFF, word index driven on both read_addr buses when idle

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_write  in  NUM_REQ  1 = write, 0 = read
req_wide  in  NUM_REQ  1 = 16-bit access, 0 = 8-bit access
req_addr  in  16*NUM_REQ  byte address; requester i uses [16i+15:16i]
req_wdata  in  16*NUM_REQ  write data; narrow access uses [7:0]
req_ready  out  NUM_REQ  one-hot accept
rsp_valid  out  NUM_REQ  one-cycle completion pulse per requester
rsp_rdata  out  16  read data, qualified by rsp_valid
busy  out  1  high when state is not IDLE
read_addr_even, read_addr_odd  out  15 each  bank read word index
write_addr_even, write_addr_odd  out  15 each  bank write word index
write_data_even, write_data_odd  out  8 each  bank write data
write_en_even, write_en_odd  out  1 each  bank write strobes
read_data_even, read_data_odd  in  8 each  bank read data, registered in iosystem (valid the cycle after the address)

Behaviour:
- Reset state:
  - state IDLE; req_ready, rsp_valid, write_en_* = 0; rsp_rdata = 0.
  - read_addr_* = IDLE_RADDR; write_addr_* = IDLE_RADDR^1; write_data_* = 0.
  - Round-robin pointer makes requester 0 highest priority.
- States IDLE -> ISSUE -> (read: WAIT) -> IDLE.
- IDLE:
  - Round-robin among set req_valid bits; the winner gets req_ready high combinationally.
  - Accept on req_valid&&req_ready: latch write/wide/addr/wdata/index, then go to ISSUE.
  - The pointer moves so the winner becomes lowest priority.
  - req_ready is 0 in every other state.
  - Requesters hold their request stable until accepted.
- Byte lane mapping for address A, with W = A[15:1]:
  - Low byte goes to odd bank if A[0], else even bank, at index W.
  - Wide high byte goes to the other bank, at index W if A[0]=0, else W+1 (mod 2^15).
  - Unaligned wide access is therefore a single bank cycle.
  - A=16'hFFFF wide: odd index 7FFF, even index 0000.
- ISSUE, registered outputs, valid the whole cycle:
  - Write: drive write_addr/data on the used lanes and pulse write_en only on the used lanes (narrow = one lane).
  - Read: drive read_addr on the used lanes, with write_en_* = 0.
- Forwarding guard, all states:
  - write_addr_x = read_addr_x ^ 15'h0001 whenever write_en_x = 0.
  - During a write, read_addr_x = write_addr_x ^ 1.
  - Unused lanes park at IDLE_RADDR and its ^1.
- Write completion: ISSUE -> IDLE. rsp_valid[idx] is high in the next cycle (T+2, with T = accept cycle), and IDLE may accept in that same cycle.
- Read completion:
  - ISSUE -> WAIT; in WAIT, capture read_data_* at the clock edge, then go to IDLE.
  - rsp_valid[idx] and rsp_rdata are registered and valid in cycle T+3.
  - rsp_rdata = {high-lane byte, low-lane byte}.
  - Narrow reads return {8'h00, byte}.
  - rsp_rdata holds its value until the next read response.
- Throughput: write = 1 per 2 cycles; read = 1 per 3 cycles.
- busy = (state != IDLE).
- Reset asserted at any point:
  - Immediate return to reset values; the in-flight transaction is dropped with no rsp_valid.
  - A partially issued write may already have been committed by the iosystem.
- Zero-length idle: with no req_valid, outputs stay parked and no write_en is ever asserted.

Test Plan:
- Req0 wide write A=0x0022, D=0xBEEF -> ISSUE cycle: write_addr_even=write_addr_odd=0x0011, data_even=0xEF, data_odd=0xBE, both write_en=1; rsp_valid[0] at T+2.
- Req1 wide read A=0x0023 -> read_addr_odd=0x0011, read_addr_even=0x0012, write_en=00; model returns odd=0x34, even=0x12 -> rsp_rdata=0x1234 at T+3.
- Narrow write A=0x0031, D=0x005A -> only write_en_odd=1, write_addr_odd=0x0018, data_odd=0x5A; write_en_even=0.
- Narrow read A=0x0028 -> read_addr_even=0x0014, write_addr_even=0x0015, no write_en; rsp_rdata=0x00xx with the even byte.
- Both requesters hold req_valid with 4 writes each -> grants alternate 0,1,0,1...; no requester is granted twice in a row while the other waits.
- Wide read A=0xFFFF -> odd idx 0x7FFF, even idx 0x0000.
- reset pulsed during WAIT -> busy=0, rsp_valid=00, read_addr_*=7FFF immediately; the next request after reset is granted to requester 0.
